// File: rtl/game_move_engine.sv
// 2048 move engine: slides/merges a working copy line by line, spawns one LFSR-placed tile, commits atomically.
// Optional build macro SCORE_EN enables merge scoring on the score output (tied to 0 otherwise).
module game_move_engine #(
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter logic [3:0]  FOUR_CHANCE = 4'd1,
    parameter logic [3:0]  WIN_CODE    = 4'd11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        move_up,
    input  logic        move_down,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        load_en,
    input  logic [63:0] load_grid,
    output logic [63:0] grid_flat,
    output logic        busy,
    output logic        done,
    output logic        moved,
    output logic        won,
    output logic [19:0] score
);
    typedef enum logic [1:0] {ST_IDLE, ST_LINE, ST_SPAWN, ST_COMMIT} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    state_t      state_q;
    dir_t        dir_q, dir_d;
    logic [1:0]  k_q;
    logic [3:0]  grid_q [16];
    logic [3:0]  work_q [16];
    logic        changed_q;
    logic [3:0]  spawn_base_q, scan_q, spawn_code_q, spawn_idx;
    logic [15:0] lfsr_q, lfsr_d;
    logic        busy_q, done_q, moved_q, won_q;
    logic        any_move, work_win;

    logic [3:0]  line_idx [4];
    logic [3:0]  line_in  [4];
    logic [3:0]  line_out [4];
    logic [3:0]  packed_l [5];
    logic [2:0]  n_fill, o_fill;
    logic        skip, line_diff;
    logic [3:0]  merged;
`ifdef SCORE_EN
    logic [16:0] line_pts;
`endif

    assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign any_move  = move_up | move_down | move_left | move_right;
    assign spawn_idx = spawn_base_q + scan_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign moved     = moved_q;
    assign won       = won_q;

    always_comb begin
        dir_d = DIR_RIGHT;
        if (move_up)        dir_d = DIR_UP;
        else if (move_down) dir_d = DIR_DOWN;
        else if (move_left) dir_d = DIR_LEFT;
    end

    always_comb begin
        grid_flat = '0;
        work_win  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            grid_flat[4*i +: 4] = grid_q[i];
            if (work_q[i] >= WIN_CODE) work_win = 1'b1;
        end
    end

    // Element e=0 is the cell the line slides toward; cell index is {x, y}.
    always_comb begin
        for (int e = 0; e < 4; e++) begin
            case (dir_q)
                DIR_UP:   line_idx[e] = {k_q, 2'(e)};
                DIR_DOWN: line_idx[e] = {k_q, 2'(3 - e)};
                DIR_LEFT: line_idx[e] = {2'(e), k_q};
                default:  line_idx[e] = {2'(3 - e), k_q};
            endcase
            line_in[e] = work_q[line_idx[e]];
        end
    end

    always_comb begin
        for (int e = 0; e < 5; e++) packed_l[e] = 4'd0;
        for (int e = 0; e < 4; e++) line_out[e] = 4'd0;
        n_fill    = 3'd0;
        o_fill    = 3'd0;
        skip      = 1'b0;
        merged    = 4'd0;
        line_diff = 1'b0;
`ifdef SCORE_EN
        line_pts  = '0;
`endif
        for (int e = 0; e < 4; e++) begin
            if (line_in[e] != 4'd0) begin
                packed_l[n_fill] = line_in[e];
                n_fill = n_fill + 3'd1;
            end
        end
        // A merged tile consumes its partner, so the partner is skipped and cannot merge again.
        for (int i = 0; i < 4; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else begin
                if (packed_l[i] != 4'd0 && packed_l[i] == packed_l[i+1]) begin
                    merged = (packed_l[i] == 4'hF) ? 4'hF : packed_l[i] + 4'd1;
                    line_out[o_fill[1:0]] = merged;
                    skip = 1'b1;
`ifdef SCORE_EN
                    line_pts = line_pts + (17'd1 << merged);
`endif
                end else begin
                    line_out[o_fill[1:0]] = packed_l[i];
                end
                o_fill = o_fill + 3'd1;
            end
        end
        for (int e = 0; e < 4; e++) if (line_out[e] != line_in[e]) line_diff = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_UP;
            k_q          <= 2'd0;
            changed_q    <= 1'b0;
            spawn_base_q <= 4'd0;
            scan_q       <= 4'd0;
            spawn_code_q <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            moved_q      <= 1'b0;
            won_q        <= 1'b0;
            lfsr_q       <= LFSR_SEED;
            for (int i = 0; i < 16; i++) begin
                grid_q[i] <= (i == 5 || i == 10) ? 4'd1 : 4'd0;
                work_q[i] <= 4'd0;
            end
        end else begin
            lfsr_q <= lfsr_d;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_en) begin
                        for (int i = 0; i < 16; i++) grid_q[i] <= load_grid[4*i +: 4];
                        won_q <= 1'b0;
                    end else if (any_move) begin
                        dir_q     <= dir_d;
                        k_q       <= 2'd0;
                        changed_q <= 1'b0;
                        work_q    <= grid_q;
                        busy_q    <= 1'b1;
                        state_q   <= ST_LINE;
                    end
                end
                ST_LINE: begin
                    for (int e = 0; e < 4; e++) work_q[line_idx[e]] <= line_out[e];
                    changed_q <= changed_q | line_diff;
                    k_q       <= k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        if (changed_q | line_diff) begin
                            spawn_base_q <= lfsr_q[3:0];
                            spawn_code_q <= (lfsr_q[7:4] < FOUR_CHANCE) ? 4'd2 : 4'd1;
                            scan_q       <= 4'd0;
                            state_q      <= ST_SPAWN;
                        end else begin
                            state_q <= ST_COMMIT;
                        end
                    end
                end
                ST_SPAWN: begin
                    if (work_q[spawn_idx] == 4'd0) begin
                        work_q[spawn_idx] <= spawn_code_q;
                        state_q           <= ST_COMMIT;
                    end else begin
                        scan_q <= scan_q + 4'd1;
                        if (scan_q == 4'd15) state_q <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    grid_q  <= work_q;
                    moved_q <= changed_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    if (work_win) won_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef SCORE_EN
    logic [19:0] score_q, work_score_q;
    logic [20:0] score_sum;
    assign score_sum = {1'b0, work_score_q} + 21'(line_pts);
    assign score     = score_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            score_q      <= '0;
            work_score_q <= '0;
        end else if (state_q == ST_IDLE) begin
            if (load_en) begin
                score_q      <= '0;
                work_score_q <= '0;
            end else if (any_move) begin
                work_score_q <= score_q;
            end
        end else if (state_q == ST_LINE) begin
            work_score_q <= score_sum[20] ? 20'hFFFFF : score_sum[19:0];
        end else if (state_q == ST_COMMIT) begin
            score_q <= work_score_q;
        end
    end
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_game_move_engine.sv
// Bench for game_move_engine: directed steps plus randomized grids/moves against a queue-based 2048 model.
module tb_game_move_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        move_up = 1'b0, move_down = 1'b0, move_left = 1'b0, move_right = 1'b0;
  logic        load_en = 1'b0;
  logic [63:0] load_grid = '0;
  logic [63:0] grid_flat;
  logic        busy, done, moved, won;
  logic [19:0] score;

  game_move_engine dut (
    .clk(clk), .reset(reset),
    .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
    .load_en(load_en), .load_grid(load_grid),
    .grid_flat(grid_flat), .busy(busy), .done(done), .moved(moved), .won(won), .score(score)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model state
  int          mg [16];
  int          mscore;
  bit          mwon;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] pack_model();
    logic [63:0] v = '0;
    for (int i = 0; i < 16; i++) v[4*i +: 4] = 4'(mg[i]);
    return v;
  endfunction

  function automatic logic [19:0] exp_score();
`ifdef SCORE_EN
    return 20'(mscore);
`else
    return 20'd0;
`endif
  endfunction

  function automatic int cell_of(input int dir, input int k, input int e);
    case (dir)
      0:       return 4*k + e;
      1:       return 4*k + 3 - e;
      2:       return 4*e + k;
      default: return 4*(3-e) + k;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) mg[i] = 0;
    mg[5] = 1;
    mg[10] = 1;
    mscore = 0;
    mwon = 0;
  endfunction

  task automatic model_move(input int dir, input logic [15:0] l0, output bit changed, output int n_scan);
    logic [15:0] l4 = l0;
    int s, code;
    changed = 0;
    n_scan = 0;
    for (int k = 0; k < 4; k++) begin
      int q[$];
      int outl[$];
      for (int e = 0; e < 4; e++) if (mg[cell_of(dir, k, e)] != 0) q.push_back(mg[cell_of(dir, k, e)]);
      while (q.size() > 0) begin
        if (q.size() >= 2 && q[0] == q[1]) begin
          int v = (q[0] + 1 > 15) ? 15 : q[0] + 1;
          outl.push_back(v);
          mscore = mscore + (1 << v);
          if (mscore > 20'hFFFFF) mscore = 20'hFFFFF;
          void'(q.pop_front());
          void'(q.pop_front());
        end else begin
          outl.push_back(q.pop_front());
        end
      end
      while (outl.size() < 4) outl.push_back(0);
      for (int e = 0; e < 4; e++) begin
        if (mg[cell_of(dir, k, e)] != outl[e]) changed = 1;
        mg[cell_of(dir, k, e)] = outl[e];
      end
    end
    if (changed) begin
      for (int i = 0; i < 4; i++) l4 = lfsr_step(l4);
      s = int'(l4[3:0]);
      code = (l4[7:4] < 4'd1) ? 2 : 1;
      for (int n = 0; n < 16; n++) begin
        if (mg[(s + n) % 16] == 0) begin
          mg[(s + n) % 16] = code;
          n_scan = n + 1;
          break;
        end
      end
    end
    for (int i = 0; i < 16; i++) if (mg[i] >= 11) mwon = 1;
  endtask

  task automatic do_load(input string tag);
    logic [63:0] img;
    img = pack_model();
    @(negedge clk);
    load_en = 1'b1;
    load_grid = img;
    @(negedge clk);
    load_en = 1'b0;
    mwon = 0;
    mscore = 0;
    check({tag, ":load_grid"}, grid_flat, img);
    check({tag, ":load_won"}, 64'(won), 64'(mwon));
    check({tag, ":load_done"}, 64'(done), 64'd0);
  endtask

  // mask bit0=up bit1=down bit2=left bit3=right; extra_down injects a down pulse mid-move
  task automatic do_move(input logic [3:0] mask, input bit extra_down, input string tag);
    bit changed;
    int n_scan, lat, dir, n_done;
    logic [15:0] l0;
    @(negedge clk);
    l0 = m_lfsr;
    {move_right, move_left, move_down, move_up} = mask;
    dir = mask[0] ? 0 : mask[1] ? 1 : mask[2] ? 2 : 3;
    model_move(dir, l0, changed, n_scan);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      {move_right, move_left, move_down, move_up} = 4'b0000;
      if (extra_down && c == 2) move_down = 1'b1;
      if (c == 3) check({tag, ":busy_mid"}, 64'(busy), 64'd1);
      if (done) begin
        lat = c;
        break;
      end
    end
    check({tag, ":latency"}, 64'(lat), 64'(changed ? 6 + n_scan : 6));
    check({tag, ":grid"}, grid_flat, pack_model());
    check({tag, ":moved"}, 64'(moved), 64'(changed));
    check({tag, ":won"}, 64'(won), 64'(mwon));
    check({tag, ":score"}, 64'(score), 64'(exp_score()));
    check({tag, ":busy_end"}, 64'(busy), 64'd0);
    if (extra_down) begin
      n_done = 0;
      for (int c = 0; c < 25; c++) begin
        @(negedge clk);
        if (done) n_done++;
      end
      check({tag, ":extra_done"}, 64'(n_done), 64'd0);
      check({tag, ":grid_after"}, grid_flat, pack_model());
    end
  endtask

  initial begin
    bit          ch;
    int          r;
    // 1: reset image
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset:grid", grid_flat, pack_model());
    check("reset:busy", 64'(busy), 64'd0);
    check("reset:done", 64'(done), 64'd0);
    check("reset:moved", 64'(moved), 64'd0);
    check("reset:won", 64'(won), 64'd0);
    check("reset:score", 64'(score), 64'd0);

    // 2: row0 all ones, slide left
    for (int i = 0; i < 16; i++) mg[i] = 0;
    for (int x = 0; x < 4; x++) mg[4*x] = 1;
    do_load("row_ones");
    do_move(4'b0100, 1'b0, "row_left");

    // 3: checkerboard, no merge possible
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++) mg[4*x + y] = ((x + y) % 2 != 0) ? 2 : 1;
    do_load("checker");
    do_move(4'b1000, 1'b0, "checker_right");

    // 4: column of 10s merges into 2048; won sticky afterwards
    for (int i = 0; i < 16; i++) mg[i] = 0;
    mg[0] = 10;
    mg[1] = 10;
    do_load("col_tens");
    do_move(4'b0001, 1'b0, "win_up");
    do_move(4'b1000, 1'b0, "win_right");
    do_move(4'b0010, 1'b0, "win_down");

    // 5: simultaneous up+left, down pulse while busy
    for (int i = 0; i < 16; i++) mg[i] = 0;
    mg[1] = 1; mg[4] = 1; mg[7] = 2; mg[13] = 2;
    do_load("prio");
    do_move(4'b0101, 1'b1, "prio_up_left");

    // saturation at code 15, chained moves accumulating score
    for (int i = 0; i < 16; i++) mg[i] = 15;
    do_load("sat");
    do_move(4'b0100, 1'b0, "sat_left");
    do_move(4'b0001, 1'b0, "sat_up");
    do_move(4'b1000, 1'b0, "sat_right");
    do_move(4'b0010, 1'b0, "sat_down");

    // randomized grids and moves
    for (int it = 0; it < 16; it++) begin
      if (it == 0 || $urandom_range(0, 2) != 0) begin
        for (int i = 0; i < 16; i++) begin
          r = $urandom_range(0, 99);
          mg[i] = (r < 45) ? 0 : (r < 95) ? $urandom_range(1, 4) : $urandom_range(10, 15);
        end
        do_load("rand");
      end
      do_move(4'($urandom_range(1, 15)), 1'b0, "rand_move");
    end

    // 6: reset while spawning
    for (int i = 0; i < 16; i++) mg[i] = 0;
    mg[0] = 1;
    mg[4] = 1;
    do_load("spawn_rst");
    @(negedge clk);
    move_left = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      move_left = 1'b0;
    end
    check("spawn_rst:busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    check("spawn_rst:grid", grid_flat, pack_model());
    check("spawn_rst:busy0", 64'(busy), 64'd0);
    check("spawn_rst:done0", 64'(done), 64'd0);
    check("spawn_rst:score", 64'(score), 64'd0);
    reset = 1'b0;
    ch = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) ch = 1;
    end
    check("spawn_rst:no_done", 64'(ch), 64'd0);
    do_move(4'b0010, 1'b0, "after_rst_down");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
